// File: rtl/mem_rd_arb_pkg.sv
// mem_rd_arb_pkg: shared defaults and tag type
// for the memblk read-port arbiter.
package mem_rd_arb_pkg;

  localparam int NREQ_DEF = 36;
  localparam int AW_DEF   = 39;
  localparam int PW_DEF   = 40;
  localparam int DW_DEF   = 533;

  typedef logic [5:0] tag_t;

  // Next requester index, wrapping at n.
  function automatic tag_t wrap_inc(
    input tag_t i,
    input int   n
  );
    if (int'(i) >= n - 1) return '0;
    return i + tag_t'(1);
  endfunction

endpackage

// File: rtl/mem_rd_arb_tagq.sv
// mem_rd_arb_tagq: in-order FIFO of grant tags
// awaiting read data from memblk.
module mem_rd_arb_tagq
  import mem_rd_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTRW  = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  tag_t          push_tag,
  input  logic          pop,
  output tag_t          head,
  output logic          full,
  output logic          empty,
  output logic [PTRW:0] count
);

  localparam int CW = PTRW + 1;

  tag_t            mem [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Tag storage; contents are don't-care when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTRW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTRW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: round-robin share of the memblk read port.
// Optional starvation aging under MEM_RD_ARB_AGING_EN.
module mem_rd_arbiter
  import mem_rd_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int PW   = PW_DEF,
  parameter int DW   = DW_DEF,
  parameter int TAGQ = 4
`ifdef MEM_RD_ARB_AGING_EN
  ,
  parameter int AGE_MAX = 15
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*PW-1:0] req_phy,
  output logic [NREQ-1:0]   req_ready,
  input  logic              mem_stall,
  output logic              mem_rden,
  output logic [AW-1:0]     mem_addr,
  output logic [PW-1:0]     mem_phy,
  input  logic              mem_rvalid,
  input  logic [DW-1:0]     mem_rdata,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_data,
  output logic              err_orphan
);

  localparam int QCW = $clog2(TAGQ) + 1;

  tag_t            ptr;
  tag_t            rr_idx;
  tag_t            gnt_idx;
  tag_t            q_head;
  logic [6:0]      rr_sum;
  logic            rr_hit;
  logic            gnt_hit;
  logic            q_full;
  logic            q_empty;
  logic [QCW-1:0]  q_count;
  logic            q_room;
  logic            hs;
  logic            pop;
  logic [NREQ-1:0] rsp_nxt;

  // Round-robin scan of req_valid starting at ptr.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    rr_sum = '0;
    for (int k = 0; k < NREQ; k++) begin
      rr_sum = {1'b0, ptr} + 7'(k);
      if (rr_sum >= 7'(NREQ)) rr_sum = rr_sum - 7'(NREQ);
      if (!rr_hit && req_valid[rr_sum[5:0]]) begin
        rr_hit = 1'b1;
        rr_idx = rr_sum[5:0];
      end
    end
  end

`ifdef MEM_RD_ARB_AGING_EN
  localparam int AGW = $clog2(AGE_MAX + 1);

  logic [AGW-1:0] age [NREQ];
  tag_t           age_idx;
  logic           age_hit;

  // Lowest-index starved requester overrides round-robin.
  always_comb begin
    age_hit = 1'b0;
    age_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i] && age[i] == AGW'(AGE_MAX)) begin
        age_hit = 1'b1;
        age_idx = tag_t'(i);
      end
    end
  end

  assign gnt_hit = age_hit | rr_hit;
  assign gnt_idx = age_hit ? age_idx : rr_idx;

  // Saturating wait counters, cleared on grant or idle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (!rst_n || !req_valid[i]) begin
        age[i] <= '0;
      end else if (hs && gnt_idx == tag_t'(i)) begin
        age[i] <= '0;
      end else if (age[i] != AGW'(AGE_MAX)) begin
        age[i] <= age[i] + AGW'(1);
      end
    end
  end
`else
  assign gnt_hit = rr_hit;
  assign gnt_idx = rr_idx;
`endif

  // Full queue blocks grants even when a pop is in flight.
  assign q_room = (q_count != QCW'(TAGQ)) & ~q_full;
  assign hs     = rst_n & ~mem_stall & q_room & gnt_hit;
  assign pop    = mem_rvalid & ~q_empty;

  // One-hot grant.
  always_comb begin
    req_ready = '0;
    if (hs) req_ready[gnt_idx] = 1'b1;
  end

  // One-hot response strobe for the queue head.
  always_comb begin
    rsp_nxt = '0;
    if (pop) rsp_nxt[q_head] = 1'b1;
  end

  mem_rd_arb_tagq #(
    .DEPTH (TAGQ)
  ) u_tagq (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (hs),
    .push_tag (gnt_idx),
    .pop      (pop),
    .head     (q_head),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  // Issue register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= '0;
      mem_rden <= 1'b0;
      mem_addr <= '0;
      mem_phy  <= '0;
    end else begin
      mem_rden <= hs;
      if (hs) begin
        ptr      <= wrap_inc(gnt_idx, NREQ);
        mem_addr <= req_addr[gnt_idx*AW +: AW];
        mem_phy  <= req_phy[gnt_idx*PW +: PW];
      end
    end
  end

  // Response return and sticky orphan flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid  <= '0;
      rsp_data   <= '0;
      err_orphan <= 1'b0;
    end else begin
      rsp_valid  <= rsp_nxt;
      if (pop) rsp_data <= mem_rdata;
      err_orphan <= err_orphan | (mem_rvalid & q_empty);
    end
  end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// tb_mem_rd_arbiter: directed checks of grant order,
// queue-full bubble, stall, in-order responses, orphan.
`timescale 1ns/1ps
module tb_mem_rd_arbiter;

  localparam int NREQ = 36;
  localparam int AW   = 39;
  localparam int PW   = 40;
  localparam int DW   = 533;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*PW-1:0] req_phy;
  logic [NREQ-1:0]    req_ready;
  logic               mem_stall;
  logic               mem_rden;
  logic [AW-1:0]      mem_addr;
  logic [PW-1:0]      mem_phy;
  logic               mem_rvalid;
  logic [DW-1:0]      mem_rdata;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               err_orphan;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_rd_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_phy    (req_phy),
    .req_ready  (req_ready),
    .mem_stall  (mem_stall),
    .mem_rden   (mem_rden),
    .mem_addr   (mem_addr),
    .mem_phy    (mem_phy),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .err_orphan (err_orphan)
  );

  task automatic chk(
    input string        tag,
    input logic [599:0] obs,
    input logic [599:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int n);
    logic [NREQ-1:0] v;
    v    = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_addr   = '0;
    req_phy    = '0;
    mem_stall  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    req_addr[0*AW +: AW] = 39'h0AA;
    req_addr[2*AW +: AW] = 39'h222;
    req_addr[5*AW +: AW] = 39'h123;
    req_addr[7*AW +: AW] = 39'h777;
    req_phy[5*PW +: PW]  = 40'h55;
    req_phy[7*PW +: PW]  = 40'h77;
    tick;
    tick;

    // reset state
    req_valid = '1;
    #1;
    chk("rst_ready", req_ready, '0);
    req_valid = '0;
    rst_n     = 1'b1;
    #1;
    chk("rst_rden", mem_rden, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_phy", mem_phy, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_orphan", err_orphan, 0);

    // single grant, then ptr=6 picks 7 before 2
    req_valid = oh(5);
    #1;
    chk("g5_ready", req_ready, oh(5));
    tick;
    req_valid = oh(7) | oh(2);
    #1;
    chk("g5_rden", mem_rden, 1);
    chk("g5_addr", mem_addr, 39'h123);
    chk("g5_phy", mem_phy, 40'h55);
    chk("ptr6_ready", req_ready, oh(7));
    tick;
    req_valid = oh(2);
    #1;
    chk("g7_addr", mem_addr, 39'h777);
    chk("g7_phy", mem_phy, 40'h77);
    chk("g2_ready", req_ready, oh(2));
    tick;
    req_valid  = '0;
    mem_rvalid = 1'b1;
    mem_rdata  = 533'h1;
    #1;
    chk("g2_rden", mem_rden, 1);
    chk("g2_addr", mem_addr, 39'h222);
    tick;
    mem_rdata = 533'hA;
    #1;
    chk("rsp5_v", rsp_valid, oh(5));
    chk("rsp5_d", rsp_data, 533'h1);
    chk("idle_rden", mem_rden, 0);
    chk("hold_addr", mem_addr, 39'h222);
    tick;
    mem_rdata = 533'hB;
    #1;
    chk("rsp7_v", rsp_valid, oh(7));
    chk("rsp7_d", rsp_data, 533'hA);
    tick;
    mem_rvalid = 1'b0;
    #1;
    chk("rsp2_v", rsp_valid, oh(2));
    chk("rsp2_d", rsp_data, 533'hB);
    tick;
    chk("rsp_idle", rsp_valid, 0);
    chk("no_orphan", err_orphan, 0);

    // fill queue from ptr=3, bubble, resume
    req_valid = '1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("fill_ready", req_ready, oh(3 + k));
      tick;
    end
    chk("full_blk0", req_ready, '0);
    tick;
    chk("full_blk1", req_ready, '0);
    chk("full_rden", mem_rden, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = 533'hC;
    #1;
    chk("full_bubble", req_ready, '0);
    tick;
    mem_rvalid = 1'b0;
    #1;
    chk("resume_ready", req_ready, oh(7));
    chk("full_rsp_v", rsp_valid, oh(3));
    chk("full_rsp_d", rsp_data, 533'hC);
    tick;
    chk("refull", req_ready, '0);
    req_valid  = '0;
    mem_rvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (k == 3) mem_rvalid = 1'b0;
      #1;
      chk("drain_rsp", rsp_valid, oh(4 + k));
    end

    // back-to-back throughput from ptr=0
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    #1;
    chk("rst2_rsp", rsp_valid, 0);
    req_valid = '1;
    for (int k = 0; k < 40; k++) begin
      mem_rvalid = (k >= 3);
      mem_rdata  = 533'(k + 100);
      #1;
      chk("tp_ready", req_ready, oh(k % 36));
      if (k >= 1) chk("tp_rden", mem_rden, 1);
      if (k >= 4) begin
        chk("tp_rsp_v", rsp_valid, oh((k - 4) % 36));
        chk("tp_rsp_d", rsp_data, 533'(k + 99));
      end
      tick;
    end
    req_valid = '0;
    for (int k = 40; k < 43; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 533'(k + 100);
      #1;
      chk("tp_tail_v", rsp_valid, oh(k - 40));
      tick;
    end
    mem_rvalid = 1'b0;
    #1;
    chk("tp_last_v", rsp_valid, oh(3));
    chk("tp_last_d", rsp_data, 533'(142));

    // stall holds off grant; pop continues in stall
    tick;
    req_valid = oh(0);
    mem_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_ready", req_ready, '0);
      chk("stall_rden", mem_rden, 0);
      tick;
    end
    mem_stall = 1'b0;
    #1;
    chk("unstall_ready", req_ready, oh(0));
    tick;
    req_valid = '0;
    #1;
    chk("unstall_rden", mem_rden, 1);
    chk("unstall_addr", mem_addr, 39'h0AA);
    mem_stall  = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 533'hD;
    tick;
    mem_stall  = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    chk("stall_pop_v", rsp_valid, oh(0));
    chk("stall_pop_d", rsp_data, 533'hD);

    // requester 1 waits 15 stalled cycles, then races 2
    rst_n = 1'b0;
    tick;
    rst_n     = 1'b1;
    req_valid = oh(1);
    #1;
    chk("age_g1", req_ready, oh(1));
    tick;
    mem_stall = 1'b1;
    for (int k = 0; k < 15; k++) tick;
    mem_stall = 1'b0;
    req_valid = oh(1) | oh(2);
    #1;
`ifdef MEM_RD_ARB_AGING_EN
    chk("age_pick", req_ready, oh(1));
`else
    chk("rr_pick", req_ready, oh(2));
`endif
    tick;
    req_valid = '0;

    // reset with tags in flight, then orphan data
    rst_n = 1'b0;
    tick;
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 533'hE;
    #1;
    chk("orph_pre", err_orphan, 0);
    tick;
    mem_rvalid = 1'b0;
    #1;
    chk("orph_set", err_orphan, 1);
    chk("orph_rsp", rsp_valid, 0);
    tick;
    tick;
    chk("orph_hold", err_orphan, 1);
    chk("orph_rsp2", rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
